// File: rtl/gray_monitor_pkg.sv
// Shared definitions for the Gray-code monitor: FSM states and error codes.
package gray_monitor_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Error codes reported on ErrCode (and latched while in FAULT)
  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_START = 2'b01,
    ERR_STEP  = 2'b10,
    ERR_OVF   = 2'b11
  } err_code_t;

endpackage

// File: rtl/gray_monitor_gray2bin.sv
// Combinational Gray-to-binary decoder of parameterised width.
module gray_monitor_gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  // b[i] = b[i+1] ^ g[i] unrolls to the XOR of all Gray bits from i upward;
  // writing it as a slice reduction keeps every bit a pure function of g.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign b[gi] = ^g[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_monitor.sv
// Online checker/decoder for a Gray-code counter: decodes the code, checks
// every transition and the overflow flag against a shadow model, counts laps
// and latches the first deviation as a sticky coded error.
module gray_monitor
  import gray_monitor_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int LAP_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             En,
  input  logic [WIDTH-1:0] Gray,
  input  logic             Overflow,
  output logic [WIDTH-1:0] Binary,
  output logic [LAP_W-1:0] Laps,
  output logic             Error,
  output logic [1:0]       ErrCode
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [LAP_W-1:0] LAPS_MAX = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state_reg, state_next;
  err_code_t        err_code_reg, err_code_next;
  logic [WIDTH-1:0] prev_reg, prev_next;
  logic             en_d_reg, en_d_next;
  logic             ovf_sh_reg, ovf_sh_next;
  logic [LAP_W-1:0] laps_reg, laps_next;
  logic [WIDTH-1:0] binary_reg;

  logic [WIDTH-1:0] gray_bin;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] step_bin;
  logic [WIDTH-1:0] expected_gray;
  logic             prev_at_max;

  gray_monitor_gray2bin #(.WIDTH(WIDTH)) u_dec_gray (
    .g (Gray),
    .b (gray_bin)
  );

  gray_monitor_gray2bin #(.WIDTH(WIDTH)) u_dec_prev (
    .g (prev_reg),
    .b (prev_bin)
  );

  // The counter advanced iff En was high on the edge before prev was sampled
  always_comb begin
    step_bin      = prev_bin + ONE;
    expected_gray = en_d_reg ? (step_bin ^ (step_bin >> 1)) : prev_reg;
    prev_at_max   = (prev_bin == ALL_ONES);
  end

  // State and shadow-model registers; Binary decodes on every non-reset edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      err_code_reg <= ERR_NONE;
      prev_reg     <= '0;
      en_d_reg     <= 1'b0;
      ovf_sh_reg   <= 1'b0;
      laps_reg     <= '0;
      binary_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      err_code_reg <= err_code_next;
      prev_reg     <= prev_next;
      en_d_reg     <= en_d_next;
      ovf_sh_reg   <= ovf_sh_next;
      laps_reg     <= laps_next;
      binary_reg   <= gray_bin;
    end
  end

  // Next-state logic: Clear resyncs from any state, then the per-state checks
  always_comb begin
    state_next    = state_reg;
    err_code_next = err_code_reg;
    prev_next     = prev_reg;
    en_d_next     = en_d_reg;
    ovf_sh_next   = ovf_sh_reg;
    laps_next     = laps_reg;

    if (Clear) begin
      state_next    = ST_IDLE;
      err_code_next = ERR_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          prev_next   = Gray;
          en_d_next   = En;
          ovf_sh_next = 1'b0;
          if (Gray != '0 || Overflow) begin
            state_next    = ST_FAULT;
            err_code_next = ERR_START;
          end else begin
            state_next = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (Gray != expected_gray) begin
            state_next    = ST_FAULT;
            err_code_next = ERR_STEP;
          end else if (Overflow != ovf_sh_reg) begin
            state_next    = ST_FAULT;
            err_code_next = ERR_OVF;
          end else begin
            prev_next   = Gray;
            en_d_next   = En;
            ovf_sh_next = ovf_sh_reg | prev_at_max;
            if (en_d_reg && prev_at_max && laps_reg != LAPS_MAX) begin
              laps_next = laps_reg + LAP_W'(1);
            end
          end
        end
        default: begin
          // FAULT: everything frozen until Clear or Reset
        end
      endcase
    end
  end

  // Outputs: Error is simply "currently in FAULT"
  always_comb begin
    Binary  = binary_reg;
    Laps    = laps_reg;
    Error   = (state_reg == ST_FAULT);
    ErrCode = err_code_reg;
  end

endmodule

// File: tb/tb_gray_monitor.sv
// Self-checking bench for gray_monitor: golden upstream counter, behavioural
// monitor model compared every cycle, plus directed literal expectations.
module tb_gray_monitor;

  localparam int WIDTH   = 3;
  localparam int LAP_W   = 2;
  localparam int MAXV    = 7;
  localparam int LAP_MAX = 3;

  logic             Clk = 1'b0;
  logic             Reset, Clear, En, Overflow;
  logic [WIDTH-1:0] Gray;
  logic [WIDTH-1:0] Binary;
  logic [LAP_W-1:0] Laps;
  logic             Error;
  logic [1:0]       ErrCode;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // golden upstream counter
  int up_cnt, up_last_max;
  bit up_ovf;

  // input overrides for fault injection
  bit               force_gray, force_ovf, forced_ovf;
  logic [WIDTH-1:0] forced_gray;

  // behavioural monitor model
  bit m_synced, m_faulted, m_en_d, m_ovf_sh;
  int m_pb, m_laps, m_code, m_bin;

  gray_monitor #(.WIDTH(WIDTH), .LAP_W(LAP_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clear    (Clear),
    .En       (En),
    .Gray     (Gray),
    .Overflow (Overflow),
    .Binary   (Binary),
    .Laps     (Laps),
    .Error    (Error),
    .ErrCode  (ErrCode)
  );

  always #5 Clk = ~Clk;

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 0; i < WIDTH; i++) b = b ^ (g >> i);
    return b & MAXV;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & MAXV;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit c, input bit e, input int g, input bit ov);
    int want;
    if (r) begin
      m_synced = 0; m_faulted = 0; m_en_d = 0; m_ovf_sh = 0;
      m_pb = 0; m_laps = 0; m_code = 0; m_bin = 0;
      return;
    end
    m_bin = g2b(g);
    if (c) begin
      m_synced = 0; m_faulted = 0; m_code = 0;
    end else if (m_faulted) begin
      m_code = m_code;
    end else if (!m_synced) begin
      m_pb = g2b(g); m_en_d = e; m_ovf_sh = 0;
      if (g != 0 || ov) begin m_faulted = 1; m_code = 1; end
      else m_synced = 1;
    end else begin
      want = (m_pb + (m_en_d ? 1 : 0)) % (MAXV + 1);
      if (g2b(g) != want) begin
        m_faulted = 1; m_code = 2;
      end else if (ov != m_ovf_sh) begin
        m_faulted = 1; m_code = 3;
      end else begin
        if (m_en_d && m_pb == MAXV && m_laps < LAP_MAX) m_laps++;
        if (m_pb == MAXV) m_ovf_sh = 1;
        m_pb = g2b(g); m_en_d = e;
      end
    end
  endtask

  task automatic upstream_edge(input bit r, input bit e);
    if (r) begin
      up_cnt = 0; up_last_max = 0; up_ovf = 0;
    end else begin
      up_ovf      = up_ovf | (up_last_max != 0);
      up_last_max = (up_cnt == MAXV) ? 1 : 0;
      up_cnt      = (up_cnt + (e ? 1 : 0)) % (MAXV + 1);
    end
  endtask

  // one clock: drive inputs, take the edge, advance model and upstream
  task automatic cycle(input bit r, input bit c, input bit e);
    int g;
    bit ov;
    Reset = r; Clear = c; En = e;
    g  = force_gray ? int'(forced_gray) : b2g(up_cnt);
    ov = force_ovf ? forced_ovf : up_ovf;
    Gray = WIDTH'(g); Overflow = ov;
    @(posedge Clk);
    model_edge(r, c, e, g, ov);
    upstream_edge(r, e);
    #1;
  endtask

  // per-cycle comparison against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      cmp("model_binary",  int'(Binary),  m_bin);
      cmp("model_laps",    int'(Laps),    m_laps);
      cmp("model_error",   int'(Error),   int'(m_faulted));
      cmp("model_errcode", int'(ErrCode), m_code);
    end
  end

  int t1_bin [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
  bit t2_en  [6]  = '{1, 0, 0, 1, 1, 0};
  int t2_bin [6]  = '{0, 1, 1, 1, 2, 3};

  initial begin
    Reset = 1; Clear = 0; En = 0; Gray = '0; Overflow = 0;
    force_gray = 0; force_ovf = 0; forced_ovf = 0; forced_gray = '0;
    upstream_edge(1, 0);
    model_edge(1, 0, 0, 0, 0);

    cycle(1, 0, 0);
    chk_en = 1;
    cmp("reset_binary", int'(Binary), 0);
    cmp("reset_laps", int'(Laps), 0);
    cmp("reset_error", int'(Error), 0);
    cmp("reset_errcode", int'(ErrCode), 0);
    $display("reset: Binary=%0d Laps=%0d Error=%0d ErrCode=%0d", Binary, Laps, Error, ErrCode);

    // counting run across one wrap
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1);
      cmp("t1_binary", int'(Binary), t1_bin[i]);
      $display("t1 cycle %0d: Gray=%0d Overflow=%0d Binary=%0d Laps=%0d Error=%0d", i, Gray, Overflow, Binary, Laps, Error);
    end
    cmp("t1_laps", int'(Laps), 1);
    cmp("t1_error", int'(Error), 0);
    cmp("t1_model_laps", m_laps, 1);

    // enable gaps hold the code without error
    cycle(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, t2_en[i]);
      cmp("t2_binary", int'(Binary), t2_bin[i]);
      $display("t2 cycle %0d: En=%0d Gray=%0d Binary=%0d Error=%0d", i, t2_en[i], Gray, Binary, Error);
    end
    cmp("t2_error", int'(Error), 0);

    // illegal step, stickiness, clear and resync
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    force_gray = 1; forced_gray = 3'b011;
    cycle(0, 0, 1);
    force_gray = 0;
    cmp("t3_error", int'(Error), 1);
    cmp("t3_errcode", int'(ErrCode), 2);
    cycle(0, 0, 1);
    cmp("t3_sticky_error", int'(Error), 1);
    cmp("t3_sticky_errcode", int'(ErrCode), 2);
    $display("t3 step fault: Error=%0d ErrCode=%0d", Error, ErrCode);
    cycle(0, 1, 0);
    cmp("t3_clear_error", int'(Error), 0);
    cmp("t3_clear_errcode", int'(ErrCode), 0);
    force_gray = 1; forced_gray = 3'b000;
    repeat (4) cycle(0, 0, 0);
    cmp("t3_resync_error", int'(Error), 0);
    $display("t3 resync: Error=%0d ErrCode=%0d", Error, ErrCode);

    // clear coinciding with a bad step wins
    forced_gray = 3'b101;
    cycle(0, 1, 0);
    cmp("clr_win_error", int'(Error), 0);
    cmp("clr_win_errcode", int'(ErrCode), 0);
    forced_gray = 3'b000;
    repeat (2) cycle(0, 0, 0);
    cmp("clr_win_after", int'(Error), 0);
    force_gray = 0;
    $display("clear-wins: Error=%0d ErrCode=%0d", Error, ErrCode);

    // overflow mismatch at count 3, laps frozen afterwards
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 1);
    force_ovf = 1; forced_ovf = 1;
    cycle(0, 0, 1);
    force_ovf = 0;
    cmp("t4_errcode", int'(ErrCode), 3);
    cmp("t4_error", int'(Error), 1);
    repeat (10) cycle(0, 0, 1);
    cmp("t4_laps_frozen", int'(Laps), 0);
    cmp("t4_errcode_held", int'(ErrCode), 3);
    $display("t4 overflow fault: ErrCode=%0d Laps=%0d", ErrCode, Laps);

    // step error outranks overflow error
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    force_gray = 1; forced_gray = 3'b110; force_ovf = 1; forced_ovf = 1;
    cycle(0, 0, 1);
    force_gray = 0; force_ovf = 0;
    cmp("prio_errcode", int'(ErrCode), 2);
    $display("priority: ErrCode=%0d", ErrCode);

    // bad start value
    cycle(1, 0, 0);
    force_gray = 1; forced_gray = 3'b001;
    cycle(0, 0, 1);
    force_gray = 0;
    cmp("t5_errcode", int'(ErrCode), 1);
    cmp("t5_error", int'(Error), 1);
    $display("t5 bad start: Error=%0d ErrCode=%0d", Error, ErrCode);

    // reset out of FAULT
    cycle(1, 0, 0);
    cmp("rst_fault_error", int'(Error), 0);
    cmp("rst_fault_errcode", int'(ErrCode), 0);

    // lap saturation, then reset mid-run
    repeat (42) cycle(0, 0, 1);
    cmp("t6_laps_sat", int'(Laps), 3);
    cmp("t6_error", int'(Error), 0);
    $display("t6 saturation: Laps=%0d Error=%0d", Laps, Error);
    cycle(1, 0, 1);
    cmp("t6_rst_laps", int'(Laps), 0);
    cmp("t6_rst_binary", int'(Binary), 0);
    $display("t6 reset: Laps=%0d Binary=%0d", Laps, Binary);

    chk_en = 0;
    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
